// File: rtl/phinc_ctrl.sv
// Phase-increment controller: debounced up/down buttons with hold-to-repeat,
// plus host loads with priority, saturating to [PHINC_MIN, PHINC_MAX].
module phinc_ctrl #(
   parameter int unsigned DEB_CYC   = 20000,
   parameter int unsigned HOLD_CYC  = 100000,
   parameter int unsigned REP_CYC   = 25000,
   parameter int unsigned CNT_W     = 20,
   parameter logic [7:0]  PHINC_RST = 8'd1,
   parameter logic [7:0]  PHINC_MIN = 8'd0,
   parameter logic [7:0]  PHINC_MAX = 8'd255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       phase_up,
   input  logic       phase_dn,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   output logic [7:0] phinc,
   output logic       phinc_upd,
   output logic       at_limit
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_e;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_e;

   // Bit 0 is the UP button, bit 1 the DN button; all levels active-low.
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;

   state_e            state_q, state_d;
   dir_e              dir_q, dir_d, dir;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              step;

   logic [7:0] phinc_q, phinc_d;
   logic       chg_q, upd_q, ld_ready_q;
   logic       ld_fire;

   function automatic logic [7:0] clamp(input int v);
      if (v < int'(PHINC_MIN))      return PHINC_MIN;
      else if (v > int'(PHINC_MAX)) return PHINC_MAX;
      else                          return 8'(v);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         deb_q     <= '1;
         deb_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments let the two sync stages sample the old value of each other in one edge.
         sync1_q   <= {phase_dn, phase_up};
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      deb_d     = deb_q;
      deb_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
            else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      dir = DIR_NONE;
      if (!deb_q[0] && deb_q[1])      dir = DIR_UP;
      else if (deb_q[0] && !deb_q[1]) dir = DIR_DN;
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      step    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dir != DIR_NONE) begin
               step    = 1'b1;
               dir_d   = dir;
               cnt_d   = '0;
               state_d = S_HOLD;
            end
         end
         S_HOLD, S_REPEAT: begin
            if (dir != dir_q) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == ((state_q == S_HOLD) ? HOLD_LAST : REP_LAST)) begin
               step    = 1'b1;
               cnt_d   = '0;
               state_d = S_REPEAT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         dir_q   <= DIR_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
      end
   end

   // A load wins outright; a step in the same cycle is simply lost.
   assign ld_fire = ld_valid & ld_ready_q;

   always_comb begin
      phinc_d = phinc_q;
      if (ld_fire)                  phinc_d = clamp(int'(ld_data));
      else if (step && dir == DIR_UP) phinc_d = clamp(int'(phinc_q) + 1);
      else if (step && dir == DIR_DN) phinc_d = clamp(int'(phinc_q) - 1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phinc_q    <= PHINC_RST;
         chg_q      <= 1'b0;
         upd_q      <= 1'b0;
         ld_ready_q <= 1'b0;
      end else begin
         phinc_q    <= phinc_d;
         chg_q      <= (phinc_d != phinc_q);
         upd_q      <= chg_q;
         ld_ready_q <= 1'b1;
      end
   end

   assign phinc     = phinc_q;
   assign phinc_upd = upd_q;
   assign ld_ready  = ld_ready_q;
   assign at_limit  = (phinc_q == PHINC_MIN) || (phinc_q == PHINC_MAX);

endmodule

// File: tb/tb_phinc_ctrl.sv
// Directed bench for phinc_ctrl with short debounce/hold/repeat times.
module tb_phinc_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       phase_up = 1'b1;
   logic       phase_dn = 1'b1;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'd0;
   logic       ld_ready;
   logic [7:0] phinc;
   logic       phinc_upd;
   logic       at_limit;

   int checks   = 0;
   int failures = 0;
   int upd_cnt  = 0;

   phinc_ctrl #(
      .DEB_CYC  (4),
      .HOLD_CYC (16),
      .REP_CYC  (8),
      .CNT_W    (20),
      .PHINC_RST(8'd1),
      .PHINC_MIN(8'd0),
      .PHINC_MAX(8'd10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .phase_up (phase_up),
      .phase_dn (phase_dn),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .phinc    (phinc),
      .phinc_upd(phinc_upd),
      .at_limit (at_limit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each and counting update pulses.
   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (phinc_upd === 1'b1) upd_cnt++;
      end
   endtask

   initial begin
      // Reset values
      tick_n(2);
      check("rst_phinc", 32'(phinc), 32'd1);
      check("rst_upd", 32'(phinc_upd), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_at_limit", 32'(at_limit), 32'd0);
      reset = 1'b1;
      tick_n(2);
      check("ld_ready_run", 32'(ld_ready), 32'd1);

      // Short UP glitch is filtered
      upd_cnt  = 0;
      phase_up = 1'b0;
      tick_n(3);
      phase_up = 1'b1;
      tick_n(15);
      check("glitch_phinc", 32'(phinc), 32'd1);
      check("glitch_upd", 32'(upd_cnt), 32'd0);

      // Single step: press-to-change latency 2+4+1, update pulse one cycle later
      upd_cnt  = 0;
      phase_up = 1'b0;
      tick_n(6);
      check("press_lat_early", 32'(phinc), 32'd1);
      tick_n(1);
      check("press_lat", 32'(phinc), 32'd2);
      check("upd_not_yet", 32'(phinc_upd), 32'd0);
      tick_n(1);
      check("upd_pulse", 32'(phinc_upd), 32'd1);
      tick_n(1);
      check("upd_one_cycle", 32'(phinc_upd), 32'd0);
      tick_n(1);
      phase_up = 1'b1;
      tick_n(25);
      check("single_phinc", 32'(phinc), 32'd2);
      check("single_upd_cnt", 32'(upd_cnt), 32'd1);

      // UP held 100 cycles: steps at 7, 23, then every 8, saturating at 10
      upd_cnt  = 0;
      phase_up = 1'b0;
      tick_n(7);
      check("rep_first", 32'(phinc), 32'd3);
      tick_n(15);
      check("rep_hold_wait", 32'(phinc), 32'd3);
      tick_n(1);
      check("rep_hold_step", 32'(phinc), 32'd4);
      tick_n(8);
      check("rep_repeat_step", 32'(phinc), 32'd5);
      tick_n(39);
      check("rep_pre_sat", 32'(phinc), 32'd9);
      check("rep_pre_sat_lim", 32'(at_limit), 32'd0);
      tick_n(1);
      check("rep_sat", 32'(phinc), 32'd10);
      check("rep_sat_lim", 32'(at_limit), 32'd1);
      tick_n(29);
      check("rep_sat_hold", 32'(phinc), 32'd10);
      check("rep_upd_cnt", 32'(upd_cnt), 32'd8);
      phase_up = 1'b1;
      tick_n(20);

      // DN held 200 cycles: descend to 0, no wrap
      upd_cnt  = 0;
      phase_dn = 1'b0;
      tick_n(7);
      check("dn_first", 32'(phinc), 32'd9);
      tick_n(80);
      check("dn_floor", 32'(phinc), 32'd0);
      check("dn_floor_lim", 32'(at_limit), 32'd1);
      tick_n(113);
      check("dn_no_wrap", 32'(phinc), 32'd0);
      check("dn_upd_cnt", 32'(upd_cnt), 32'd10);
      phase_dn = 1'b1;
      tick_n(20);

      // Load 7 in the cycle a button step is issued: load wins, step dropped
      upd_cnt  = 0;
      phase_up = 1'b0;
      tick_n(6);
      ld_valid = 1'b1;
      ld_data  = 8'd7;
      tick_n(1);
      ld_valid = 1'b0;
      check("load_prio", 32'(phinc), 32'd7);
      tick_n(1);
      check("load_upd", 32'(phinc_upd), 32'd1);
      tick_n(1);
      phase_up = 1'b1;
      tick_n(25);
      check("step_dropped", 32'(phinc), 32'd7);
      check("load_upd_cnt", 32'(upd_cnt), 32'd1);

      // Both buttons together: no steps
      upd_cnt  = 0;
      phase_up = 1'b0;
      phase_dn = 1'b0;
      tick_n(40);
      check("both_phinc", 32'(phinc), 32'd7);
      check("both_upd_cnt", 32'(upd_cnt), 32'd0);
      phase_up = 1'b1;
      phase_dn = 1'b1;
      tick_n(20);

      // Load 200 clamps to 10; reloading the same value gives no update
      upd_cnt  = 0;
      ld_valid = 1'b1;
      ld_data  = 8'd200;
      tick_n(1);
      ld_valid = 1'b0;
      check("load_clamp", 32'(phinc), 32'd10);
      check("load_clamp_lim", 32'(at_limit), 32'd1);
      tick_n(3);
      check("load_clamp_upd", 32'(upd_cnt), 32'd1);
      upd_cnt  = 0;
      ld_valid = 1'b1;
      ld_data  = 8'd10;
      tick_n(1);
      ld_valid = 1'b0;
      tick_n(3);
      check("load_same_no_upd", 32'(upd_cnt), 32'd0);

      // Reset during REPEAT with UP held, then re-debounced press
      ld_valid = 1'b1;
      ld_data  = 8'd3;
      tick_n(1);
      ld_valid = 1'b0;
      tick_n(3);
      check("load_3", 32'(phinc), 32'd3);
      phase_up = 1'b0;
      tick_n(35);
      check("pre_rst_repeat", 32'(phinc), 32'd6);
      reset = 1'b0;
      #1;
      check("rst_async_phinc", 32'(phinc), 32'd1);
      check("rst_async_ready", 32'(ld_ready), 32'd0);
      check("rst_async_upd", 32'(phinc_upd), 32'd0);
      tick_n(2);
      reset = 1'b1;
      tick_n(6);
      check("post_rst_early", 32'(phinc), 32'd1);
      tick_n(1);
      check("post_rst_step", 32'(phinc), 32'd2);
      phase_up = 1'b1;
      tick_n(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
